mem_access_unit: RTL

- MEM-stage memory controller for the pipelined LC-3b core. Sits directly downstream of the EX/MEM pipeline buffer.
- Turns the buffered memory operation (ALU-computed address, store data, op type) into request/response transactions on data port B.
- Handles byte/word loads and stores and the two-access indirect ops LDI/STI.
- Drives a stall to freeze the pipeline until the access completes, and presents load data to the MEM/WB buffer.

---
 rtl/mem_access_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: LC-3b MEM-stage controller driving port B for byte/word/indirect loads and stores
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [2:0]  mem_op,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    input  logic        advance,
    input  logic        resp_b,
    input  logic [15:0] rdata_b,
    output logic        read_b,
    output logic        write_b,
    output logic [1:0]  wmask_b,
    output logic [15:0] address_b,
    output logic [15:0] wdata_b,
    output logic        stall,
    output logic [15:0] load_data,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, IND, ACC, DONE} state_t;
    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d, sdata_q, sdata_d;
    logic        read_q, read_d, write_q, write_d, done_q, done_d;
    logic [1:0]  wmask_q, wmask_d;
    logic [15:0] address_q, address_d, wdata_q, wdata_d, load_q, load_d;
    logic        start, from_idle;
    logic [2:0]  acc_op;
    logic [15:0] acc_addr, acc_sd;
    // codes 000 and 100 both have op[1:0]==00 and are treated as NONE
    assign start     = valid & (mem_op[1:0] != 2'b00);
    assign from_idle = state_q == IDLE;
    // the data access is set up either straight from EX or from the indirect pointer
    assign acc_op    = from_idle ? mem_op : op_q;
    assign acc_addr  = from_idle ? addr : rdata_b;
    assign acc_sd    = from_idle ? store_data : sdata_q;
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        read_d    = read_q;
        write_d   = write_q;
        wmask_d   = wmask_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        load_d    = load_q;
        case (state_q)
            IDLE: if (start) begin
                op_d    = mem_op;
                addr_d  = addr;
                sdata_d = store_data;
                state_d = &mem_op[1:0] ? IND : ACC;
            end
            IND: if (resp_b) begin
                addr_d  = rdata_b;
                state_d = ACC;
            end
            ACC: if (resp_b) begin
                state_d = DONE;
                load_d  = op_q[2] ? load_q :
                          op_q[1:0] == 2'b10 ? {8'h00, addr_q[0] ? rdata_b[15:8] : rdata_b[7:0]} :
                          rdata_b;
            end
            DONE: if (advance) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == IND && from_idle) begin
            read_d    = 1'b1;
            write_d   = 1'b0;
            wmask_d   = 2'b00;
            address_d = {addr[15:1], 1'b0};
        end
        if (state_d == ACC && state_q != ACC) begin
            read_d    = ~acc_op[2];
            write_d   = acc_op[2];
            wmask_d   = !acc_op[2] ? 2'b00 : acc_op[1:0] == 2'b10 ? (acc_addr[0] ? 2'b10 : 2'b01) : 2'b11;
            address_d = {acc_addr[15:1], 1'b0};
            wdata_d   = acc_op[1:0] == 2'b10 ? {acc_sd[7:0], acc_sd[7:0]} : acc_sd;
        end
        if (state_d == DONE) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            wmask_d = 2'b00;
        end
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 3'b000;
            addr_q    <= 16'h0000;
            sdata_q   <= 16'h0000;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wmask_q   <= 2'b00;
            address_q <= 16'h0000;
            wdata_q   <= 16'h0000;
            load_q    <= 16'h0000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            wmask_q   <= wmask_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            load_q    <= load_d;
            done_q    <= done_d;
        end
    end
    assign stall     = (from_idle & start) | (state_q == IND) | (state_q == ACC);
    assign read_b    = read_q;
    assign write_b   = write_q;
    assign wmask_b   = wmask_q;
    assign address_b = address_q;
    assign wdata_b   = wdata_q;
    assign load_data = load_q;
    assign done      = done_q;
endmodule
